alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the tiny16 combinational ALU. Same opcode map, same O/C/N/Z flag set.
- Generalised to WIDTH bits, with a valid/ready handshake on the input and a valid pulse on the output.
- MUL and DIV are iterative multi-cycle operations. They deliver a full double-width product, or a quotient and remainder.
- Sits between decode and register writeback in the execute stage. The control FSM stalls on in_ready low.

Parameters:
WIDTH, 16, operand/result width in bits (>= 4)
SHW, $clog2(WIDTH), internal counter/shift-amount width (derived, do not override)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept an operation this cycle
opcode  in  4  3 ADD, 4 SUB, 5 MUL, 6 DIV, 7 AND, 8 OR, 9 XOR, 10 SHL, 11 SHR; other codes = NOP
ar_flag  in  1  arithmetic shift select for SHL/SHR
src1  in  WIDTH  operand A
src2  in  WIDTH  operand B / shift amount
out_valid  out  1  one-cycle pulse: dst/dst_hi/flags/div_zero are new
dst  out  WIDTH  result low word / quotient
dst_hi  out  WIDTH  MUL high word, DIV remainder, else 0
flags  out  4  {O,C,N,Z}
div_zero  out  1  last DIV had src2 == 0

Behaviour:
- Reset (async assert, synchronous release)
  - outputs: in_ready=1, out_valid=0, dst=0, dst_hi=0, flags=0, div_zero=0
  - FSM to IDLE; counters cleared
  - reset mid-MUL/DIV aborts silently; no out_valid is produced
- Handshake
  - an op is accepted on a rising edge with in_valid && in_ready
  - opcode, ar_flag, src1 and src2 are sampled only at acceptance
- FSM states: IDLE, MUL, DIV
  - in_ready = (state == IDLE)
  - in_ready is never dependent on in_valid or on out_valid
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SHL, SHR, NOP)
  - latency 1: op accepted at edge E gives out_valid high for the cycle after E
  - state stays IDLE, so back-to-back ops sustain 1 op/cycle
- MUL (unsigned shift-add)
  - accept at E: state -> MUL, counter = WIDTH, in_ready drops
  - one iteration per edge; result registered at edge E+WIDTH
  - out_valid high for the cycle after E+WIDTH; state -> IDLE in that same cycle
  - {dst_hi,dst} = src1*src2, full 2*WIDTH bits
- DIV (unsigned restoring)
  - same timing as MUL: WIDTH iterations, latency WIDTH
  - dst = quotient, dst_hi = remainder
  - src2 == 0: dst = all ones, dst_hi = src1, div_zero=1, and the full latency is still taken
  - div_zero is updated only on DIV results, and cleared by the next DIV with nonzero divisor
- Outputs hold their values until the next out_valid; out_valid is high for exactly one cycle per op
- in_valid is ignored while in_ready=0; dropped requests are the caller's responsibility
- Arithmetic (WIDTH-bit operands, WIDTH+1-bit internal result for ADD/SUB)
  - ADD: C = carry out
  - ADD: O = (a[msb]==b[msb]) && (r[msb]!=a[msb])
  - SUB: C = borrow (src1 < src2 unsigned)
  - SUB: O = (a[msb]!=b[msb]) && (r[msb]!=a[msb])
  - MUL: C = O = (dst_hi != 0)
  - DIV, logic ops, shifts, NOP: C = O = 0
  - N = dst[msb] and Z = (dst == 0) for all ops
  - NOP: dst=0, dst_hi=0, flags=0001
- Shifts
  - amount = full src2 value
  - amount >= WIDTH: result 0, except arithmetic SHR, which gives all sign bits
  - ar_flag affects SHR only; arithmetic SHL equals logical SHL
  - dst_hi = 0 for shifts

Test Plan:
- Reset asserted during MUL iteration 5 with WIDTH=16 -> immediately in_ready=1, out_valid=0, dst=0, flags=0; no late out_valid after release.
- Back-to-back ADD 0x7FFF+0x0001, then SUB 0x0000-0x0001 -> out_valid on consecutive cycles:
  - ADD gives dst=0x8000, flags=1010
  - SUB gives dst=0xFFFF, flags=0110
- MUL 0x1234*0x5678 accepted at edge E:
  - in_ready=0 for 16 cycles
  - out_valid only in the cycle after E+16
  - dst=0x0060, dst_hi=0x0626, flags=1100
  - in_valid held high throughout gives exactly one accept
- DIV 0x0064/0x0007 -> dst=0x000E, dst_hi=0x0002, div_zero=0, flags=0000.
- DIV 0x1234/0x0000 -> same latency as DIV above; dst=0xFFFF, dst_hi=0x1234, div_zero=1, flags=0010.
- SHR 0x8001 by 4: ar=1 -> 0xF800; ar=0 -> 0x0800.
- SHR 0x8001 by 20: ar=1 -> 0xFFFF; ar=0 -> 0x0000 with Z=1.
- SHL 0x0001 by 15 -> 0x8000, N=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU: single-cycle ops give out_valid one cycle after accept, MUL/DIV after WIDTH cycles.
// Backpressure: in_ready is low only while an iterative MUL/DIV is in flight; requests during that time are ignored.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic             ar_flag,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  output logic [WIDTH-1:0] dst,
  output logic [WIDTH-1:0] dst_hi,
  output logic [3:0]       flags,
  output logic             div_zero
);

  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;

  localparam int               CW   = SHW + 1;
  localparam logic [WIDTH-1:0] WMAX = WIDTH'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] alu_lo;
  logic             alu_c, alu_o;
  logic [SHW-1:0]   shamt;
  logic             shift_big;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rsh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] it_hi, it_lo;

  assign in_ready  = (state == IDLE);
  assign shamt     = src2[SHW-1:0];
  assign shift_big = (src2 >= WMAX);

  always_comb begin
    wide   = '0;
    alu_lo = '0;
    alu_c  = 1'b0;
    alu_o  = 1'b0;
    case (opcode)
      OP_ADD: begin
        wide   = {1'b0, src1} + {1'b0, src2};
        alu_lo = wide[WIDTH-1:0];
        alu_c  = wide[WIDTH];
        alu_o  = (src1[WIDTH-1] == src2[WIDTH-1]) && (wide[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SUB: begin
        wide   = {1'b0, src1} - {1'b0, src2};
        alu_lo = wide[WIDTH-1:0];
        alu_c  = wide[WIDTH];
        alu_o  = (src1[WIDTH-1] != src2[WIDTH-1]) && (wide[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_AND: alu_lo = src1 & src2;
      OP_OR:  alu_lo = src1 | src2;
      OP_XOR: alu_lo = src1 ^ src2;
      OP_SHL: alu_lo = shift_big ? '0 : (src1 << shamt);
      OP_SHR: begin
        if (shift_big)
          alu_lo = (ar_flag && src1[WIDTH-1]) ? '1 : '0;
        else if (ar_flag)
          alu_lo = $signed(src1) >>> shamt;
        else
          alu_lo = src1 >> shamt;
      end
      default: alu_lo = '0;
    endcase
  end

  // One shift-add (MUL) or restoring-subtract (DIV) step over {hi_q, lo_q}.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_rsh  = {hi_q, lo_q[WIDTH-1]};
    div_ge   = (div_rsh >= {1'b0, b_q});
    div_diff = div_rsh[WIDTH-1:0] - b_q;
    if (state == MUL) begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      it_hi = div_ge ? div_diff : div_rsh[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      dst       <= '0;
      dst_hi    <= '0;
      flags     <= '0;
      div_zero  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (opcode == OP_MUL || opcode == OP_DIV) begin
              state <= (opcode == OP_MUL) ? MUL : DIV;
              cnt   <= CW'(WIDTH);
              hi_q  <= '0;
              lo_q  <= src1;
              b_q   <= src2;
            end else begin
              out_valid <= 1'b1;
              dst       <= alu_lo;
              dst_hi    <= '0;
              flags     <= {alu_o, alu_c, alu_lo[WIDTH-1], ~|alu_lo};
            end
          end
        end
        MUL, DIV: begin
          hi_q <= it_hi;
          lo_q <= it_lo;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            dst       <= it_lo;
            dst_hi    <= it_hi;
            if (state == MUL) begin
              flags <= {|it_hi, |it_hi, it_lo[WIDTH-1], ~|it_lo};
            end else begin
              flags    <= {2'b00, it_lo[WIDTH-1], ~|it_lo};
              div_zero <= ~|b_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): driver pushes expected results, a negedge monitor pops and compares.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic        ar_flag;
  logic [15:0] src1, src2;
  logic        out_valid;
  logic [15:0] dst, dst_hi;
  logic [3:0]  flags;
  logic        div_zero;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .ar_flag(ar_flag), .src1(src1), .src2(src2),
    .out_valid(out_valid), .dst(dst), .dst_hi(dst_hi), .flags(flags), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] dst;
    logic [15:0] hi;
    logic [3:0]  fl;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_ov = 0;
  int   last_ov = 0;
  int   prev_ov = 0;
  logic m_dz = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, want);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid) begin
      n_ov++;
      prev_ov = last_ov;
      last_ov = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: actual pulse at cycle %0d required none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("result{dst,hi,flags,dz}", {dst, dst_hi, flags, div_zero}, e);
      end
    end
  end

  // Reference model: plain integer arithmetic on the operation's definition.
  function automatic exp_t model(input logic [3:0] op, input logic ar,
                                 input logic [15:0] a, input logic [15:0] b, input logic dz_in);
    exp_t        e;
    int          ua, ub, sa, sb, r;
    longint      p;
    logic        c, o;
    logic [15:0] lo, hi;
    ua = {16'h0, a};
    ub = {16'h0, b};
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0; p = 0; c = 1'b0; o = 1'b0; lo = '0; hi = '0;
    e.dz = dz_in;
    case (op)
      4'd3: begin
        r = ua + ub; lo = r[15:0]; c = (r > 65535);
        o = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'd4: begin
        r = ua - ub; lo = r[15:0]; c = (ua < ub);
        o = (sa - sb > 32767) || (sa - sb < -32768);
      end
      4'd5: begin
        p = longint'(ua) * longint'(ub);
        lo = p[15:0]; hi = p[31:16]; c = (hi != 0); o = c;
      end
      4'd6: begin
        if (ub == 0) begin lo = 16'hFFFF; hi = a; e.dz = 1'b1; end
        else begin r = ua / ub; lo = r[15:0]; r = ua % ub; hi = r[15:0]; e.dz = 1'b0; end
      end
      4'd7: lo = a & b;
      4'd8: lo = a | b;
      4'd9: lo = a ^ b;
      4'd10: begin
        if (ub >= 16) lo = 16'h0;
        else begin r = ua << ub; lo = r[15:0]; end
      end
      4'd11: begin
        if (ub >= 16) lo = (ar && sa < 0) ? 16'hFFFF : 16'h0;
        else if (ar) begin r = sa >>> ub; lo = r[15:0]; end
        else begin r = ua >> ub; lo = r[15:0]; end
      end
      default: lo = 16'h0;
    endcase
    e.dst = lo;
    e.hi  = hi;
    e.fl  = {o, c, lo[15], (lo == 16'h0)};
    return e;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic ar, input logic [15:0] a,
                      input logic [15:0] b, input exp_t e, output int acc);
    int g;
    g = 0;
    acc = 0;
    opcode = op; ar_flag = ar; src1 = a; src2 = b; in_valid = 1'b1;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual in_ready=0 after %0d cycles required 1", g);
    end else begin
      exp_q.push_back(e);
      acc = cyc + 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [3:0] op, input logic ar, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] d, input logic [15:0] h,
                          input logic [3:0] fl, input logic dz, output int acc);
    exp_t e;
    e = '{dst: d, hi: h, fl: fl, dz: dz};
    m_dz = dz;
    send(op, ar, a, b, e, acc);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(posedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual %0d pending required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc, e_cyc, low, early, n0;
    exp_t        e;
    logic [3:0]  op;
    logic        ar;
    logic [15:0] a, b;

    reset = 1'b1; in_valid = 1'b0; opcode = '0; ar_flag = 1'b0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_dst", dst, 0);
    chk("reset_dst_hi", dst_hi, 0);
    chk("reset_flags", flags, 0);
    chk("reset_div_zero", div_zero, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    send_exp(4'd3, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 4'b1010, 1'b0, acc);
    send_exp(4'd4, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 16'h0, 4'b0110, 1'b0, acc);
    drain();
    chk("add_sub_back_to_back_gap", last_ov - prev_ov, 1);

    // MUL with in_valid held high across the whole busy window.
    n0 = n_ov;
    opcode = 4'd5; ar_flag = 1'b0; src1 = 16'h1234; src2 = 16'h5678; in_valid = 1'b1;
    exp_q.push_back('{dst: 16'h0060, hi: 16'h0626, fl: 4'b1100, dz: 1'b0});
    e_cyc = cyc + 1;
    @(posedge clk); #1;
    low = 0; early = 0;
    for (int i = 0; i < 16; i++) begin
      if (!in_ready) low++;
      if (out_valid) early++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mul_ready_low_cycles", low, 16);
    chk("mul_no_early_valid", early, 0);
    chk("mul_ready_after", in_ready, 1);
    drain();
    repeat (20) @(posedge clk);
    #1;
    chk("mul_latency", last_ov - e_cyc, 16);
    chk("mul_single_accept", n_ov - n0, 1);

    send_exp(4'd6, 1'b0, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 4'b0000, 1'b0, acc);
    drain();
    chk("div_latency", last_ov - acc, 16);
    send_exp(4'd6, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 4'b0010, 1'b1, acc);
    drain();
    chk("div0_latency", last_ov - acc, 16);

    send_exp(4'd11, 1'b1, 16'h8001, 16'd4,  16'hF800, 16'h0, 4'b0010, 1'b1, acc);
    send_exp(4'd11, 1'b0, 16'h8001, 16'd4,  16'h0800, 16'h0, 4'b0000, 1'b1, acc);
    send_exp(4'd11, 1'b1, 16'h8001, 16'd20, 16'hFFFF, 16'h0, 4'b0010, 1'b1, acc);
    send_exp(4'd11, 1'b0, 16'h8001, 16'd20, 16'h0000, 16'h0, 4'b0001, 1'b1, acc);
    send_exp(4'd10, 1'b0, 16'h0001, 16'd15, 16'h8000, 16'h0, 4'b0010, 1'b1, acc);
    send_exp(4'd0,  1'b0, 16'h1234, 16'h5678, 16'h0000, 16'h0, 4'b0001, 1'b1, acc);
    drain();

    // Reset during the fifth MUL iteration aborts it silently.
    send_exp(4'd5, 1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0, 4'b0000, 1'b1, acc);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    m_dz = 1'b0;
    #1;
    chk("midmul_reset_in_ready", in_ready, 1);
    chk("midmul_reset_out_valid", out_valid, 0);
    chk("midmul_reset_dst", dst, 0);
    chk("midmul_reset_flags", flags, 0);
    chk("midmul_reset_div_zero", div_zero, 0);
    n0 = n_ov;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midmul_reset_no_late_valid", n_ov - n0, 0);

    for (int k = 0; k < 300; k++) begin
      op = 4'($urandom_range(0, 15));
      ar = 1'($urandom_range(0, 1));
      a  = rnd16();
      if ((op == 4'd10 || op == 4'd11) && $urandom_range(0, 1) == 1)
        b = 16'($urandom_range(0, 20));
      else
        b = rnd16();
      e = model(op, ar, a, b, m_dz);
      m_dz = e.dz;
      send(op, ar, a, b, e, acc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
